conv_stim_gen: RTL and testbench

Parametrised, synthesizable stimulus source for the convolution network input port. Generates frames of DATA_W-bit pixels in one of four modes (cyclic sequence, free ramp, constant, LFSR) over a valid/ready handshake, with frame framing and a frame counter. Sits in front of the convolution top-level `d_in` in simulation and on-chip self-test builds; replaces free-running hand-written pattern drivers.

---
 rtl/conv_stim_gen.sv | 139 +++++++++++++
 tb/tb_conv_stim_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/conv_stim_gen.sv
// Pattern source for the convolution input port: cyclic, ramp, constant or LFSR
// pixels over valid/ready, framed into FRAME_LEN beats with a completed-frame counter.
module conv_stim_gen #(
  parameter int                 DATA_W     = 8,
  parameter int                 SEQ_LEN    = 5,
  parameter int                 FRAME_LEN  = 784,
  parameter int                 NUM_FRAMES = 1,
  parameter logic [DATA_W-1:0]  LFSR_TAPS  = 8'hB8,
  parameter logic [DATA_W-1:0]  LFSR_SEED  = 8'h01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] base,
  output logic [DATA_W-1:0] d_out,
  output logic              d_valid,
  input  logic              d_ready,
  output logic              frame_last,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  localparam int PW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int SW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam logic [PW-1:0] PIX_LAST = PW'(FRAME_LEN - 1);
  localparam logic [SW-1:0] SEQ_LAST = SW'(SEQ_LEN - 1);
  localparam logic [15:0]   FRAMES   = 16'(NUM_FRAMES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  logic [1:0]        mode_q, mode_nxt;
  logic [DATA_W-1:0] first_q, first_nxt;
  logic [DATA_W-1:0] gen_q, gen_nxt, adv_val;
  logic [SW-1:0]     seq_q, seq_nxt, adv_seq;
  logic [PW-1:0]     pix_q, pix_nxt;
  logic              last_q, last_nxt;
  logic [15:0]       fcnt_q, fcnt_nxt;

  // An all-zero LFSR would lock up, so base 0 selects the seed instead.
  function automatic logic [DATA_W-1:0] first_val(input logic [1:0] m, input logic [DATA_W-1:0] b);
    return (m == 2'd3 && b == '0) ? LFSR_SEED : b;
  endfunction

  always_comb begin
    adv_val = gen_q;
    adv_seq = seq_q;
    case (mode_q)
      2'd0: begin
        if (seq_q == SEQ_LAST) begin
          adv_val = first_q;
          adv_seq = '0;
        end else begin
          adv_val = gen_q + 1'b1;
          adv_seq = seq_q + 1'b1;
        end
      end
      2'd1:    adv_val = gen_q + 1'b1;
      2'd2:    adv_val = gen_q;
      default: adv_val = (gen_q >> 1) ^ (gen_q[0] ? LFSR_TAPS : '0);
    endcase
  end

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    first_nxt = first_q;
    gen_nxt   = gen_q;
    seq_nxt   = seq_q;
    pix_nxt   = pix_q;
    last_nxt  = last_q;
    fcnt_nxt  = fcnt_q;
    case (state)
      IDLE: begin
        if (start) begin
          mode_nxt  = mode;
          first_nxt = first_val(mode, base);
          gen_nxt   = first_val(mode, base);
          seq_nxt   = '0;
          pix_nxt   = '0;
          last_nxt  = (PIX_LAST == '0);
          fcnt_nxt  = '0;
          state_nxt = RUN;
        end
      end
      default: begin
        if (d_ready) begin
          if (last_q) begin
            // Every frame restarts the generator so frames are identical.
            fcnt_nxt = fcnt_q + 16'd1;
            pix_nxt  = '0;
            seq_nxt  = '0;
            gen_nxt  = first_q;
            last_nxt = (PIX_LAST == '0);
            if (FRAMES != 16'd0 && fcnt_nxt == FRAMES) begin
              state_nxt = IDLE;
              last_nxt  = 1'b0;
            end
          end else begin
            pix_nxt  = pix_q + 1'b1;
            gen_nxt  = adv_val;
            seq_nxt  = adv_seq;
            last_nxt = ((pix_q + 1'b1) == PIX_LAST);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      mode_q  <= '0;
      first_q <= '0;
      gen_q   <= '0;
      seq_q   <= '0;
      pix_q   <= '0;
      last_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state   <= state_nxt;
      mode_q  <= mode_nxt;
      first_q <= first_nxt;
      gen_q   <= gen_nxt;
      seq_q   <= seq_nxt;
      pix_q   <= pix_nxt;
      last_q  <= last_nxt;
      fcnt_q  <= fcnt_nxt;
    end
  end

  assign d_out      = gen_q;
  assign d_valid    = (state == RUN);
  assign busy       = (state == RUN);
  assign frame_last = last_q;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_conv_stim_gen.sv
// Bench for conv_stim_gen: three configurations (single 784-beat frame, two 4-beat
// frames, continuous 3-beat frames) checked against an arithmetic pixel model.
module tb_conv_stim_gen;

  localparam int          SEQ_LEN = 5;
  localparam logic [7:0]  TAPS    = 8'hB8;
  localparam logic [7:0]  SEED    = 8'h01;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_ready;
  logic [1:0]  mode;
  logic [7:0]  base;
  logic [2:0]  start_v;
  logic [7:0]  dout_w  [3];
  logic        valid_w [3];
  logic        last_w  [3];
  logic        busy_w  [3];
  logic [15:0] fcnt_w  [3];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  conv_stim_gen u_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode), .base(base),
    .d_out(dout_w[0]), .d_valid(valid_w[0]), .d_ready(d_ready),
    .frame_last(last_w[0]), .busy(busy_w[0]), .frame_cnt(fcnt_w[0])
  );

  conv_stim_gen #(.FRAME_LEN(4), .NUM_FRAMES(2)) u_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode), .base(base),
    .d_out(dout_w[1]), .d_valid(valid_w[1]), .d_ready(d_ready),
    .frame_last(last_w[1]), .busy(busy_w[1]), .frame_cnt(fcnt_w[1])
  );

  conv_stim_gen #(.FRAME_LEN(3), .NUM_FRAMES(0)) u_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .mode(mode), .base(base),
    .d_out(dout_w[2]), .d_valid(valid_w[2]), .d_ready(d_ready),
    .frame_last(last_w[2]), .busy(busy_w[2]), .frame_cnt(fcnt_w[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int fl_of(input int sel);
    return (sel == 0) ? 784 : (sel == 1) ? 4 : 3;
  endfunction

  // Pixel at position k within a frame, straight from the generator rules.
  function automatic logic [7:0] exp_pix(input logic [1:0] m, input logic [7:0] b, input int k);
    logic [7:0] s;
    case (m)
      2'd0: return 8'(int'(b) + (k % SEQ_LEN));
      2'd1: return 8'(int'(b) + k);
      2'd2: return b;
      default: begin
        s = (b == 8'd0) ? SEED : b;
        for (int i = 0; i < k; i++) s = (s >> 1) ^ (s[0] ? TAPS : 8'h00);
        return s;
      end
    endcase
  endfunction

  task automatic check_reset(input int sel);
    check("rst_dout",  dout_w[sel],  0);
    check("rst_valid", valid_w[sel], 0);
    check("rst_last",  last_w[sel],  0);
    check("rst_busy",  busy_w[sel],  0);
    check("rst_fcnt",  fcnt_w[sel],  0);
  endtask

  task automatic run_stream(input int sel, input logic [1:0] m, input logic [7:0] b,
                            input int nbeats, input bit rnd, input bit toggle, input bit endchk);
    int fl = fl_of(sel);
    int k = 0;
    int cyc = 0;
    int budget = nbeats * 4 + 50;
    bit hold = 0;
    bit rdy;
    logic [7:0] pd = '0;
    logic pl = 1'b0;
    mode = m;
    base = b;
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
    while (k < nbeats && cyc < budget) begin
      rdy = rnd ? 1'($urandom % 2) : 1'b1;
      d_ready = rdy;
      if (toggle) begin
        start_v[sel] = 1'($urandom % 2);
        mode = 2'($urandom);
        base = 8'($urandom);
      end
      check("valid", valid_w[sel], 1);
      check("busy", busy_w[sel], 1);
      check("fcnt", fcnt_w[sel], 32'((k / fl) % 65536));
      if (hold) begin
        check("hold_dout", dout_w[sel], pd);
        check("hold_last", last_w[sel], pl);
      end
      if (valid_w[sel] && rdy) begin
        check("pixel", dout_w[sel], exp_pix(m, b, k % fl));
        check("frame_last", last_w[sel], 32'((k % fl) == fl - 1));
        k++;
      end
      hold = valid_w[sel] && !rdy;
      pd = dout_w[sel];
      pl = last_w[sel];
      @(negedge clk);
      cyc++;
    end
    start_v[sel] = 1'b0;
    d_ready = 1'b1;
    if (k < nbeats) check("timeout", 0, 1);
    if (endchk) begin
      check("end_valid", valid_w[sel], 0);
      check("end_busy", busy_w[sel], 0);
      check("end_fcnt", fcnt_w[sel], 32'(nbeats / fl));
      @(negedge clk);
      check("idle_valid", valid_w[sel], 0);
    end
  endtask

  initial begin
    rst = 1'b0;
    start_v = '0;
    d_ready = 1'b0;
    mode = '0;
    base = '0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) check_reset(s);
    rst = 1'b1;
    @(negedge clk);

    run_stream(0, 2'd0, 8'h01, 784, 1'b0, 1'b0, 1'b1);
    run_stream(1, 2'd1, 8'hFE, 8, 1'b0, 1'b0, 1'b1);
    run_stream(1, 2'd3, 8'h00, 8, 1'b0, 1'b0, 1'b1);
    run_stream(1, 2'd3, 8'h01, 8, 1'b1, 1'b0, 1'b1);
    run_stream(0, 2'd3, 8'h00, 784, 1'b1, 1'b0, 1'b1);
    run_stream(0, 2'd0, 8'h01, 784, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      run_stream(1, 2'($urandom), 8'($urandom), 8, 1'b1, 1'b0, 1'b1);

    run_stream(2, 2'd0, 8'h01, 31, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_reset(2);
    run_stream(2, 2'd0, 8'h07, 10, 1'b1, 1'b0, 1'b0);

    // Reset and start at the same edge: reset wins.
    rst = 1'b0;
    start_v[0] = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    start_v[0] = 1'b0;
    check("rst_vs_start_busy", busy_w[0], 0);
    check("rst_vs_start_valid", valid_w[0], 0);
    @(negedge clk);
    check("rst_vs_start_idle", busy_w[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
